// File: rtl/md_cell_pkg.sv
// Shared constants, FSM states and FIFO entry type for the cell position reader.
package md_cell_pkg;

  localparam int RD_LATENCY    = 2;
  localparam int RD_FIFO_DEPTH = 4;
  localparam int CELL_DATA_W   = 96;
  localparam int CELL_ADDR_W   = 8;
  localparam int FIFO_CNT_W    = $clog2(RD_FIFO_DEPTH + 1);
  localparam int INFLIGHT_W    = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_REQ,
    ST_CNT_WAIT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } reader_state_e;

  typedef struct packed {
    logic                   last;
    logic [CELL_ADDR_W-1:0] index;
    logic [CELL_DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic logic [INFLIGHT_W-1:0] inflight_count(input logic [RD_LATENCY-1:0] vld);
    logic [INFLIGHT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      n = n + INFLIGHT_W'(vld[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cell_reader_fifo.sv
// Four-entry show-ahead FIFO; the head entry is driven straight from storage flops.
module cell_reader_fifo
  import md_cell_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  fifo_entry_t           push_entry,
  input  logic                  pop,
  output fifo_entry_t           head,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);

  fifo_entry_t           slot_q [RD_FIFO_DEPTH];
  fifo_entry_t           slot_d [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FIFO_CNT_W'(RD_FIFO_DEPTH));
  assign count   = count_q;
  assign head    = slot_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    slot_d   = slot_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FIFO_CNT_W'(1);
      2'b01:   count_d = count_q - FIFO_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cell_pos_reader.sv
// Streams particle words 1..N of a cell RAM as a valid/ready stream.
// Define CELL_READER_CLAMP_EN to clamp oversize counts to PARTICLE_NUM-1 and flag count_err.
module cell_pos_reader
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = CELL_DATA_W,
  parameter int ADDR_WIDTH   = CELL_ADDR_W,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam int CREDIT_W = FIFO_CNT_W + 1;
  localparam int WAIT_W   = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;

  reader_state_e                         state_q, state_d;
  logic [WAIT_W-1:0]                     wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]                 particle_count_q, particle_count_d;
  logic                                  count_err_q, count_err_d;
  logic [RD_LATENCY-1:0]                 pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_idx_q, pipe_idx_d;

  logic [ADDR_WIDTH-1:0] raw_count;
  logic [ADDR_WIDTH-1:0] eff_count;
  logic                  count_over;
  logic                  issue;
  logic                  credit_ok;
  logic [CREDIT_W-1:0]   credit_used;
  logic                  out_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FIFO_CNT_W-1:0] fifo_count;
  fifo_entry_t           push_entry;
  fifo_entry_t           head;

  assign raw_count = mem_q[ADDR_WIDTH-1:0];

`ifdef CELL_READER_CLAMP_EN
  assign count_over = (raw_count > MAX_COUNT);
  assign eff_count  = count_over ? MAX_COUNT : raw_count;
  assign count_err  = count_err_q;
`else
  logic unused_cfg;
  assign count_over = 1'b0;
  assign eff_count  = raw_count;
  assign count_err  = 1'b0;
  assign unused_cfg = ^{MAX_COUNT, count_err_q};
`endif

  // Every outstanding read already owns a FIFO slot, so returning words can never overflow it.
  assign credit_used = CREDIT_W'(fifo_count) + CREDIT_W'(inflight_count(pipe_vld_q));
  assign credit_ok   = (credit_used < CREDIT_W'(RD_FIFO_DEPTH));

  assign out_valid      = !fifo_empty;
  assign out_pop        = out_valid && out_ready;
  assign out_data       = head.data;
  assign out_index      = head.index;
  assign out_last       = head.last;
  assign busy           = (state_q != ST_IDLE);
  assign mem_wren       = 1'b0;
  assign particle_count = particle_count_q;

  always_comb begin
    state_d          = state_q;
    wait_d           = '0;
    addr_d           = addr_q;
    particle_count_d = particle_count_q;
    count_err_d      = count_err_q;
    mem_rden         = 1'b0;
    mem_address      = '0;
    issue            = 1'b0;
    done             = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CNT_REQ;
          count_err_d = 1'b0;
        end
      end
      ST_CNT_REQ: begin
        mem_rden = 1'b1;
        state_d  = ST_CNT_WAIT;
      end
      ST_CNT_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        if (wait_q == WAIT_W'(RD_LATENCY - 1)) begin
          wait_d           = '0;
          particle_count_d = eff_count;
          count_err_d      = count_over;
          addr_d           = ADDR_WIDTH'(1);
          state_d          = (eff_count == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (credit_ok) begin
          issue       = 1'b1;
          mem_rden    = 1'b1;
          mem_address = addr_q;
          if (addr_q == particle_count_q) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Leave once nothing is in flight and the last buffered word is gone after this cycle.
        if ((pipe_vld_q == '0) &&
            (fifo_empty || ((fifo_count == FIFO_CNT_W'(1)) && out_pop))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pipe_vld_d       = {pipe_vld_q[RD_LATENCY-2:0], issue};
    pipe_idx_d       = {pipe_idx_q[RD_LATENCY-2:0], addr_q};
    push_entry       = '0;
    push_entry.data  = mem_q;
    push_entry.index = pipe_idx_q[RD_LATENCY-1];
    push_entry.last  = (pipe_idx_q[RD_LATENCY-1] == particle_count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      wait_q           <= '0;
      addr_q           <= '0;
      particle_count_q <= '0;
      count_err_q      <= 1'b0;
      pipe_vld_q       <= '0;
      pipe_idx_q       <= '0;
    end else begin
      state_q          <= state_d;
      wait_q           <= wait_d;
      addr_q           <= addr_d;
      particle_count_q <= particle_count_d;
      count_err_q      <= count_err_d;
      pipe_vld_q       <= pipe_vld_d;
      pipe_idx_q       <= pipe_idx_d;
    end
  end

  cell_reader_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pipe_vld_q[RD_LATENCY-1]),
    .push_entry (push_entry),
    .pop        (out_pop),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader with a 2-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_cell_pos_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, mem_rden, mem_wren, count_err, out_valid, out_last;
  logic [AW-1:0] mem_address, particle_count, out_index;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] out_data;

  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_s1 = '0;
  logic [31:0]   cur_salt = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int mon_rel;

  logic [DW-1:0] hs_data [$];
  logic [AW-1:0] hs_idx [$];
  logic          hs_last [$];
  int            hs_cyc [$];
  int done_cnt, done_cyc, busy_first, busy_last, valid_cnt, stab_err, pre_pop_reads, first_rd_cyc;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;
  logic [126:0]  snap;

  cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
    .particle_count(particle_count), .count_err(count_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rden === 1'b1) ram_s1 <= ram[mem_address];
    mem_q <= ram_s1;
  end

  // Observe the DUT mid-cycle and record handshakes, pulses and stall stability.
  always @(negedge clk) begin
    mon_rel = cyc - t0;
    if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data ||
                       out_index !== prev_idx || out_last !== prev_last)) stab_err++;
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_data  = out_data;
    prev_idx   = out_index;
    prev_last  = out_last;
    if (out_valid === 1'b1) valid_cnt++;
    if (mem_rden === 1'b1 && mem_address == AW'(1) && first_rd_cyc < 0) first_rd_cyc = mon_rel;
    if (mem_rden === 1'b1 && mem_address !== '0 && hs_idx.size() == 0) pre_pop_reads++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_data.push_back(out_data);
      hs_idx.push_back(out_index);
      hs_last.push_back(out_last);
      hs_cyc.push_back(mon_rel);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = mon_rel;
    end
    if (busy === 1'b1) begin
      if (busy_first < 0) busy_first = mon_rel;
      busy_last = mon_rel;
    end
  end

  function automatic logic [DW-1:0] exp_word(input int i, input logic [31:0] s);
    return {s + 32'(i), 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
  endfunction

  task automatic load_cell(input int cnt, input logic [31:0] s);
    cur_salt = s;
    ram[0] = {88'h5A5A5A5A5A5A5A5A5A5A5A, 8'(cnt)};
    for (int i = 1; i < 256; i++) ram[i] = exp_word(i, s);
  endtask

  task automatic clear_mon();
    hs_data.delete(); hs_idx.delete(); hs_last.delete(); hs_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
    valid_cnt = 0; stab_err = 0; pre_pop_reads = 0; first_rd_cyc = -1;
    prev_stall = 1'b0; snap = '0;
  endtask

  // Cycle k starts at posedge k; start is pulsed at k=0 plus optional re-pulses.
  task automatic run(input int n_cyc, input int rep_a, input int rep_b, input int rst_at,
                     input int lo, input int hi);
    clear_mon();
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk); #1;
      if (k == 0) t0 = cyc;
      start     = (k == 0) || (k == rep_a) || (k == rep_b);
      rst       = (k == rst_at);
      out_ready = !((k >= lo) && (k <= hi));
      @(negedge clk);
      if (rst_at >= 0 && k == rst_at + 1)
        snap = {busy, done, mem_rden, mem_wren, count_err, out_valid, out_last,
                mem_address, particle_count, out_index, out_data};
    end
    start = 1'b0; rst = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (mem_rden !== 1'b0 || mem_wren !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en got %b%b want 00", mem_rden, mem_wren); end
    checks++; if (mem_address !== '0) begin errors++; $display("[TB] FAIL reset_addr got %0h want 0", mem_address); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_last got %b%b want 00", out_valid, out_last); end
    checks++; if (out_data !== '0 || out_index !== '0) begin errors++; $display("[TB] FAIL reset_out got %h/%0h want 0/0", out_data, out_index); end
    checks++; if (particle_count !== '0 || count_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_count got %0d/%b want 0/0", particle_count, count_err); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_count3();
    load_cell(3, 32'h3000_0000);
    run(16, -1, -1, -1, -1, -1);
    checks++; if (first_rd_cyc !== 4) begin errors++; $display("[TB] FAIL c3_first_read got %0d want 4", first_rd_cyc); end
    checks++; if (hs_idx.size() !== 3) begin errors++; $display("[TB] FAIL c3_words got %0d want 3", hs_idx.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (hs_idx[i] !== AW'(i + 1)) begin errors++; $display("[TB] FAIL c3_index%0d got %0d want %0d", i, hs_idx[i], i + 1); end
      checks++; if (hs_data[i] !== exp_word(i + 1, cur_salt)) begin errors++; $display("[TB] FAIL c3_data%0d got %h want %h", i, hs_data[i], exp_word(i + 1, cur_salt)); end
      checks++; if (hs_cyc[i] !== 7 + i) begin errors++; $display("[TB] FAIL c3_cycle%0d got %0d want %0d", i, hs_cyc[i], 7 + i); end
      checks++; if (hs_last[i] !== (i == 2)) begin errors++; $display("[TB] FAIL c3_last%0d got %b want %b", i, hs_last[i], i == 2); end
    end
    checks++; if (done_cyc !== 10 || done_cnt !== 1) begin errors++; $display("[TB] FAIL c3_done got cyc %0d n %0d want cyc 10 n 1", done_cyc, done_cnt); end
    checks++; if (busy_first !== 1 || busy_last !== 10) begin errors++; $display("[TB] FAIL c3_busy got %0d..%0d want 1..10", busy_first, busy_last); end
    checks++; if (particle_count !== 8'd3) begin errors++; $display("[TB] FAIL c3_count got %0d want 3", particle_count); end
  endtask

  task automatic test_count0();
    load_cell(0, 32'h0);
    run(10, -1, -1, -1, -1, -1);
    checks++; if (valid_cnt !== 0) begin errors++; $display("[TB] FAIL c0_valid got %0d want 0", valid_cnt); end
    checks++; if (done_cyc !== 4 || done_cnt !== 1) begin errors++; $display("[TB] FAIL c0_done got cyc %0d n %0d want cyc 4 n 1", done_cyc, done_cnt); end
    checks++; if (busy_last !== 4) begin errors++; $display("[TB] FAIL c0_busy_last got %0d want 4", busy_last); end
  endtask

  task automatic test_stall();
    int bad;
    load_cell(10, 32'h5100_0000);
    run(60, -1, -1, -1, 5, 20);
    checks++; if (pre_pop_reads > 4) begin errors++; $display("[TB] FAIL stall_credit got %0d reads want <=4", pre_pop_reads); end
    checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL stall_stable got %0d changes want 0", stab_err); end
    checks++; if (hs_cyc.size() == 0 || hs_cyc[0] !== 21) begin errors++; $display("[TB] FAIL stall_first_pop got %0d want 21", hs_cyc.size() > 0 ? hs_cyc[0] : -1); end
    checks++; if (hs_idx.size() !== 10) begin errors++; $display("[TB] FAIL stall_words got %0d want 10", hs_idx.size()); end
    bad = 0;
    for (int i = 0; i < hs_idx.size(); i++)
      if (hs_idx[i] !== AW'(i + 1) || hs_data[i] !== exp_word(i + 1, cur_salt) || hs_last[i] !== (i == 9)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stall_order got %0d bad words want 0", bad); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    load_cell(3, 32'h7700_0000);
    run(16, 2, 10, -1, -1, -1);
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL restart_done got %0d want 1", done_cnt); end
    checks++; if (hs_idx.size() !== 3) begin errors++; $display("[TB] FAIL restart_words got %0d want 3", hs_idx.size()); end
    checks++; if (busy_last !== 10) begin errors++; $display("[TB] FAIL restart_busy_last got %0d want 10", busy_last); end
  endtask

  task automatic test_reset_mid();
    int bad;
    load_cell(10, 32'h8800_0000);
    run(20, -1, -1, 8, -1, -1);
    checks++; if (snap !== '0) begin errors++; $display("[TB] FAIL rmid_outputs got %h want 0", snap); end
    checks++; if (hs_idx.size() !== 2) begin errors++; $display("[TB] FAIL rmid_words got %0d want 2", hs_idx.size()); end
    checks++; if (done_cnt !== 0 || busy_last !== 8) begin errors++; $display("[TB] FAIL rmid_idle got done %0d busy_last %0d want 0/8", done_cnt, busy_last); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_fifo got %b want 0", out_valid); end
    load_cell(10, 32'h9900_0000);
    run(25, -1, -1, -1, -1, -1);
    checks++; if (hs_idx.size() !== 10) begin errors++; $display("[TB] FAIL rmid_rerun_words got %0d want 10", hs_idx.size()); end
    bad = 0;
    for (int i = 0; i < hs_idx.size(); i++)
      if (hs_idx[i] !== AW'(i + 1) || hs_data[i] !== exp_word(i + 1, cur_salt) || hs_cyc[i] !== 7 + i) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rmid_rerun_order got %0d bad words want 0", bad); end
    checks++; if (done_cyc !== 17) begin errors++; $display("[TB] FAIL rmid_rerun_done got %0d want 17", done_cyc); end
  endtask

  task automatic test_clamp();
    int bad;
    int n_exp;
    logic err_exp;
`ifdef CELL_READER_CLAMP_EN
    n_exp = PN - 1; err_exp = 1'b1;
`else
    n_exp = 250; err_exp = 1'b0;
`endif
    load_cell(250, 32'hAB00_0000);
    run(270, -1, -1, -1, -1, -1);
    checks++; if (particle_count !== AW'(n_exp)) begin errors++; $display("[TB] FAIL clamp_count got %0d want %0d", particle_count, n_exp); end
    checks++; if (count_err !== err_exp) begin errors++; $display("[TB] FAIL clamp_err got %b want %b", count_err, err_exp); end
    checks++; if (hs_idx.size() !== n_exp) begin errors++; $display("[TB] FAIL clamp_words got %0d want %0d", hs_idx.size(), n_exp); end
    bad = 0;
    for (int i = 0; i < hs_idx.size(); i++)
      if (hs_idx[i] !== AW'(i + 1) || hs_data[i] !== exp_word(i + 1, cur_salt) || hs_last[i] !== (i == n_exp - 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL clamp_order got %0d bad words want 0", bad); end
    checks++; if (done_cyc !== 7 + n_exp) begin errors++; $display("[TB] FAIL clamp_done got %0d want %0d", done_cyc, 7 + n_exp); end
  endtask

  task automatic test_back_to_back();
    int bad;
    load_cell(3, 32'hCC00_0000);
    run(30, 11, -1, -1, -1, -1);
    checks++; if (done_cnt !== 2) begin errors++; $display("[TB] FAIL b2b_done got %0d want 2", done_cnt); end
    checks++; if (hs_idx.size() !== 6) begin errors++; $display("[TB] FAIL b2b_words got %0d want 6", hs_idx.size()); end
    bad = 0;
    for (int i = 0; i < hs_idx.size(); i++)
      if (hs_idx[i] !== AW'((i % 3) + 1) || hs_data[i] !== exp_word((i % 3) + 1, cur_salt)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL b2b_order got %0d bad words want 0", bad); end
    checks++; if (hs_cyc.size() < 4 || hs_cyc[3] !== 18) begin errors++; $display("[TB] FAIL b2b_second_first got %0d want 18", hs_cyc.size() > 3 ? hs_cyc[3] : -1); end
    checks++; if (count_err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err_cleared got %b want 0", count_err); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_count3();
    test_count0();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    test_clamp();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
